// File: rtl/div_seq_if.sv
// Operand/result bundle between the controller and the multicycle divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             load;
  logic             is_signed;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output load, is_signed, dividendo, divisor,
    input  lo, hi, busy, done, div_zero
  );

  modport slave (
    input  load, is_signed, dividendo, divisor,
    output lo, hi, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// Multicycle restoring divider for DIV/DIVU: quotient to LO, remainder to HI,
// one-cycle divide-by-zero flag alongside done.
//
// state | meaning
// IDLE  | waiting for load; operands latched on load
// CHECK | zero test, absolute values, result signs
// RUN   | one restoring step per cycle, WIDTH steps
// FIXUP | sign-correct and write hi/lo (write skipped on divide-by-zero)
// DONE  | done pulse, div_zero pulse if divisor was 0
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic    Clk,
  input  logic    Reset,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  // Working remainder is one bit wider than the stored one; after the
  // restore it is always below the divisor, so WIDTH bits hold it.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          dvd_d   = bus.dividendo;
          dvs_d   = bus.divisor;
          sgn_d   = bus.is_signed;
          zero_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dvs_q == '0) begin
          zero_d  = 1'b1;
          // Zero path still passes through FIXUP (with the write suppressed)
          // so that done lands two cycles after the load edge.
          state_d = S_FIXUP;
        end else begin
          quo_d     = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
          dvs_d     = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
          neg_quo_d = sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          neg_rem_d = sgn_q && dvd_q[WIDTH-1];
          rem_d     = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (!rem_trial[WIDTH]) begin
          rem_d = rem_trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (!zero_q) begin
          lo_d = neg_quo_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.lo       = lo_q;
  assign bus.hi       = hi_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = (state_q == S_DONE) && zero_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results queued at issue, checked by a
// monitor on every done pulse; latency and busy checked by the issuing task.
module tb_div_seq;
  logic Clk;
  logic Reset;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_lo"}, bus.lo, e.lo);
        chk({e.nm, "_hi"}, bus.hi, e.hi);
        chk({e.nm, "_zero"}, {31'b0, bus.div_zero}, {31'b0, e.z});
      end
    end
  end

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    bus.load      = 1'b1;
    bus.is_signed = sgn;
    bus.dividendo = a;
    bus.divisor   = b;
    @(posedge Clk);
    #1 bus.load = 1'b0;
  endtask

  // Waits for done counting edges after the load edge; checks latency,
  // busy held until done, and the single-cycle pulse.
  task automatic wait_done(input string nm, input int elat);
    int lat;
    bit busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(posedge Clk);
    #1;
    chk({nm, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({nm, "_idle"}, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic ez, input int elat);
    exp_t e;
    e.lo = elo;
    e.hi = ehi;
    e.z  = ez;
    e.nm = nm;
    sb.push_back(e);
    start_op(sgn, a, b);
    wait_done(nm, elat);
  endtask

  initial begin
    Reset         = 1'b0;
    bus.load      = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_zero", {31'b0, bus.div_zero}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    run_op("s7_2",    1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 34);
    run_op("sm7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
    run_op("s7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34);
    run_op("sm100_m7",1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34);
    run_op("u_fff9_2",1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 34);
    run_op("u5_9",    1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34);
    run_op("pre23_6", 1'b0, 32'd23,         32'd6,          32'd3,          32'd5,          1'b0, 34);
    run_op("u9_0",    1'b0, 32'd9,          32'd0,          32'd3,          32'd5,          1'b1, 2);
    run_op("s_min_m1",1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34);
    run_op("u_max_2", 1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 34);

    // load while busy: only the first op may complete
    begin
      exp_t e;
      e.lo = 32'd10; e.hi = 32'd0; e.z = 1'b0; e.nm = "busy_load";
      sb.push_back(e);
      start_op(1'b1, 32'd50, 32'd5);
      repeat (10) @(posedge Clk);
      @(negedge Clk);
      bus.load      = 1'b1;
      bus.dividendo = 32'd100;
      bus.divisor   = 32'd7;
      @(posedge Clk);
      #1 bus.load = 1'b0;
      wait_done("busy_load", 23);
      repeat (50) @(posedge Clk);
      #1;
      chk("busy_load_no_second", 32'(sb.size()), 32'd0);
    end

    // async reset in the middle of RUN
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_lo", bus.lo, 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    run_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

    repeat (5) @(posedge Clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
